// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: D-stage stall, exception/interrupt flush request and
// MDU busy sequencing for the five-stage pipeline.
// Optional build macro PIPE_HAZARD_CTRL_PERF_EN adds saturating stall/Req
// cycle counters (stall_cnt, req_cnt).
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_A1,
  input  logic [4:0] D_A2,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic       D_md,
  input  logic [4:0] E_A3,
  input  logic [1:0] E_Tnew,
  input  logic [4:0] M_A3,
  input  logic [1:0] M_Tnew,
  input  logic       E_mult,
  input  logic       E_div,
  input  logic [4:0] M_ExcCode,
  input  logic [5:0] HWInt,
  input  logic [5:0] SR_IM,
  input  logic       SR_IE,
  input  logic       SR_EXL,
  output logic       stall,
  output logic       Req,
  output logic [4:0] ExcCode_out,
  output logic       mdu_busy,
  output logic       mdu_done
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] req_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

  localparam logic [3:0] LP_MULT_CYC = 4'(MULT_CYC);
  localparam logic [3:0] LP_DIV_CYC  = 4'(DIV_CYC);

  mdu_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_busy, r_done, w_done_nxt;

  logic w_haz_rs, w_haz_rt, w_haz_md;
  logic w_int_req, w_exc_req, w_req;

  // Register Tuse/Tnew hazards; register 0 is never a real dependency.
  always_comb begin
    w_haz_rs = (D_A1 != 5'd0) &&
               (((D_A1 == E_A3) && (D_Tuse_rs < E_Tnew)) ||
                ((D_A1 == M_A3) && (D_Tuse_rs < M_Tnew)));
    w_haz_rt = (D_A2 != 5'd0) &&
               (((D_A2 == E_A3) && (D_Tuse_rt < E_Tnew)) ||
                ((D_A2 == M_A3) && (D_Tuse_rt < M_Tnew)));
    w_haz_md = D_md && (r_busy || E_mult || E_div);
  end

  // Flush request and cause; an interrupt outranks an M-stage exception.
  always_comb begin
    w_int_req   = (|(HWInt & SR_IM)) && SR_IE && !SR_EXL;
    w_exc_req   = (M_ExcCode != 5'd0) && !SR_EXL;
    w_req       = w_int_req || w_exc_req;
    ExcCode_out = w_int_req ? 5'd0 : M_ExcCode;
  end

  assign Req      = w_req;
  assign stall    = (w_haz_rs || w_haz_rt || w_haz_md) && !w_req;
  assign mdu_busy = r_busy;
  assign mdu_done = r_done;

  // MDU state, counter and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  // MDU next state: start only from IDLE and only when no flush is pending;
  // a running operation ignores new starts and flushes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (E_mult && !w_req) begin
          w_state_nxt = MULT;
          w_cnt_nxt   = LP_MULT_CYC;
        end else if (E_div && !w_req) begin
          w_state_nxt = DIV;
          w_cnt_nxt   = LP_DIV_CYC;
        end
      end
      MULT, DIV: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_req_cnt;

  // Saturating counts of stalled and flushed cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
      r_req_cnt   <= 16'd0;
    end else begin
      if (stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_req && (r_req_cnt != '1))   r_req_cnt   <= r_req_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign req_cnt   = r_req_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table, then
// hand-written MDU sequences (latency, start suppression, reset abort).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_A1, D_A2, E_A3, M_A3, M_ExcCode, ExcCode_out;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_md, E_mult, E_div, SR_IE, SR_EXL;
  logic [5:0] HWInt, SR_IM;
  logic       stall, Req, mdu_busy, mdu_done;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] req_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .D_A1(D_A1), .D_A2(D_A2), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_md(D_md), .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
    .E_mult(E_mult), .E_div(E_div), .M_ExcCode(M_ExcCode),
    .HWInt(HWInt), .SR_IM(SR_IM), .SR_IE(SR_IE), .SR_EXL(SR_EXL),
    .stall(stall), .Req(Req), .ExcCode_out(ExcCode_out),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .req_cnt(req_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0] a1, a2;
    logic [1:0] tuse_rs, tuse_rt;
    logic       md;
    logic [4:0] e_a3;
    logic [1:0] e_tnew;
    logic [4:0] m_a3;
    logic [1:0] m_tnew;
    logic       e_div;
    logic [4:0] m_exc;
    logic [5:0] hwint, im;
    logic       ie, exl;
    logic       x_stall, x_req;
    logic [4:0] x_exc;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    D_A1 = 0; D_A2 = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_md = 0;
    E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0; E_mult = 0; E_div = 0;
    M_ExcCode = 0; HWInt = 0; SR_IM = 0; SR_IE = 0; SR_EXL = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watch an already-started op: busy for exp_len cycles, then one done pulse.
  task automatic watch_op(input string tag, input int exp_len);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    for (int i = 0; i < exp_len + 4; i++) begin
      if (mdu_busy) busy_n++;
      if (mdu_done) begin done_n++; done_at = i; end
      if (D_md) chk($sformatf("%s_stall_c%0d", tag, i), {31'd0, stall}, {31'd0, (i < exp_len)});
      step();
    end
    chk({tag, "_busy_len"}, busy_n, exp_len);
    chk({tag, "_done_cnt"}, done_n, 1);
    chk({tag, "_done_at"}, done_at, exp_len);
  endtask

  initial begin
    //            a1 a2 trs trt md eA3 eTn mA3 mTn div exc hw        im        ie exl   st rq exc
    vt[0]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 5'd0,  6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};  // load-use
    vt[1]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd8, 2'd1, 5'd8, 2'd1, 1'b0, 5'd0,  6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};  // resolved
    vt[2]  = '{5'd0, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 5'd0,  6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};  // $zero
    vt[3]  = '{5'd0, 5'd5, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 5'd0,  6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};  // rt vs M
    vt[4]  = '{5'd7, 5'd0, 2'd3, 2'd3, 1'b0, 5'd7, 2'd2, 5'd7, 2'd1, 1'b0, 5'd0,  6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};  // not used
    vt[5]  = '{5'd9, 5'd0, 2'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd10,2'd1, 1'b0, 5'd0,  6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};  // no match
    vt[6]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 5'd10, 6'h04, 6'h04, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0}; // int prio
    vt[7]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0,  6'h04, 6'h02, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0}; // masked
    vt[8]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0,  6'h04, 6'h04, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}; // IE off
    vt[9]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 5'd10, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10}; // exc
    vt[10] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd4,  6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4};  // EXL
    vt[11] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0,  6'h01, 6'h01, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0}; // int EXL
    vt[12] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 5'd0,  6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};  // md vs E_div
    vt[13] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 5'd3,  6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3};  // Req wins

    idle_inputs();
    reset = 1'b1;
    step(); step();
    chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("rst_done", {31'd0, mdu_done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, Req}, 32'd0);
    chk("rst_exc", {27'd0, ExcCode_out}, 32'd0);

    // Combinational table; reset held so E_div rows cannot start the MDU.
    for (int i = 0; i < 14; i++) begin
      D_A1 = vt[i].a1; D_A2 = vt[i].a2; D_Tuse_rs = vt[i].tuse_rs; D_Tuse_rt = vt[i].tuse_rt;
      D_md = vt[i].md; E_A3 = vt[i].e_a3; E_Tnew = vt[i].e_tnew; M_A3 = vt[i].m_a3;
      M_Tnew = vt[i].m_tnew; E_div = vt[i].e_div; M_ExcCode = vt[i].m_exc;
      HWInt = vt[i].hwint; SR_IM = vt[i].im; SR_IE = vt[i].ie; SR_EXL = vt[i].exl;
      #2;
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].x_stall});
      chk($sformatf("v%0d_req", i), {31'd0, Req}, {31'd0, vt[i].x_req});
      chk($sformatf("v%0d_exc", i), {27'd0, ExcCode_out}, {27'd0, vt[i].x_exc});
    end
    idle_inputs();
    step();
    reset = 1'b0;
    step();

    // Mult latency with D_md held high.
    D_md = 1; E_mult = 1;
    #1 chk("mult_start_stall", {31'd0, stall}, 32'd1);
    step();
    E_mult = 0;
    watch_op("mult", 5);
    D_md = 0;

    // Both starts together: mult wins (5 cycles, not 10).
    E_mult = 1; E_div = 1;
    step();
    E_mult = 0; E_div = 0;
    watch_op("both", 5);

    // Req in the start cycle suppresses E_div.
    E_div = 1; M_ExcCode = 5'd4;
    step();
    E_div = 0; M_ExcCode = 0;
    chk("sup_busy0", {31'd0, mdu_busy}, 32'd0);
    step();
    chk("sup_busy1", {31'd0, mdu_busy}, 32'd0);
    chk("sup_done", {31'd0, mdu_done}, 32'd0);

    // Div: Req mid-op does not cancel; reset in 4th cycle aborts without done.
    E_div = 1;
    step();                        // DIV cycle 1
    E_div = 0;
    step();                        // cycle 2
    M_ExcCode = 5'd6;
    #1 chk("div_req_mid", {31'd0, Req}, 32'd1);
    step();                        // cycle 3
    M_ExcCode = 0;
    chk("div_busy_after_req", {31'd0, mdu_busy}, 32'd1);
    step();                        // cycle 4
    chk("div_busy_c4", {31'd0, mdu_busy}, 32'd1);
    reset = 1'b1;
    step();
    chk("div_rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("div_rst_done", {31'd0, mdu_done}, 32'd0);
    reset = 1'b0;
    step();
    chk("div_rst_done2", {31'd0, mdu_done}, 32'd0);
    chk("div_rst_busy2", {31'd0, mdu_busy}, 32'd0);

    // Fresh div runs the full 10 cycles.
    D_md = 1; E_div = 1;
    step();
    E_div = 0;
    watch_op("div", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
